pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of consecutive memory-wait cycles before a fault.
REQ-003 SHALL have ports:
- id_rs1_addr / id_rs2_addr: input, 5 each; ID source register addresses.
- id_rs1_ren / id_rs2_ren: input, 1 each; ID source-used flags.
- ex_reg_waddr: input, 5; EX destination register.
- ex_reg_wen: input, 1; EX writes a register.
- ex_is_load: input, 1; EX holds a load.
- mem_reg_waddr: input, 5; MEM destination register.
- mem_reg_wen: input, 1; MEM writes a register.
- id_redirect: input, 1; taken branch/jump resolved in ID.
- mem_req: input, 1; MEM holds a valid load/store.
- mem_ready: input, 1; data memory completes the MEM access this cycle.
- wb_ebreak: input, 1; ebreak retiring in WB.
- if_stall: output, 1; hold the PC.
- id_stall: output, 1; hold the if/id register.
- if_id_flush: output, 1; load a NOP into if/id.
- ex_bubble: output, 1; load a NOP into id/ex.
- ex_stall: output, 1; hold id/ex.
- mem_stall: output, 1; hold ex/mem.
- wb_bubble: output, 1; load a NOP into mem/wb.
- fwd_rs1_sel / fwd_rs2_sel: output, 2 each; 0 = regfile, 1 = EX result, 2 = MEM result.
- halted: output, 1; sticky halt.
- mem_timeout: output, 1; sticky fault.
- stall_cycles: output, 32; performance counter.

Function
REQ-004 SHALL keep a registered FSM with states RUN, MEM_WAIT and HALT, and a registered 8-bit wait counter.
REQ-005 SHALL detect a hazard (hz1) when ex_is_load, ex_reg_wen, ex_reg_waddr != 0, id_rs1_ren and ex_reg_waddr == id_rs1_addr all hold; rs2 is handled identically; load_use = hz1 | hz2.
REQ-006 SHALL set mw (memory wait) = mem_req & ~mem_ready.
REQ-007 SHALL drive all stall/flush outputs as combinational functions of the state and inputs, with priority HALT > mw > load_use > id_redirect.
REQ-008 SHALL, in state HALT, assert if_stall, id_stall, ex_stall, mem_stall and wb_bubble, and deassert if_id_flush and ex_bubble.
REQ-009 SHALL, when mw is true (in RUN or MEM_WAIT), assert if_stall, id_stall, ex_stall, mem_stall and wb_bubble, and deassert all other control outputs.
REQ-010 SHALL, when load_use is true without mw, assert if_stall, id_stall and ex_bubble for exactly that cycle, with id_redirect ignored that cycle.
REQ-011 SHALL, when id_redirect is true without load_use or mw, assert if_id_flush only.
REQ-012 SHALL compute forwarding per source: select 1 if ex_reg_wen, ex_reg_waddr != 0, match and ~ex_is_load; else select 2 if mem_reg_wen, mem_reg_waddr != 0 and match; else select 0. EX has priority over MEM. x0 is never forwarded.
REQ-013 SHALL make FSM transitions as follows:
- RUN→MEM_WAIT on mw.
- MEM_WAIT→RUN when ~mw.
- Any state→HALT on wb_ebreak (unless already stalled by mw, where wb_ebreak is ignored because the WB stage holds a bubble).
- MEM_WAIT→HALT with mem_timeout set when the wait counter reaches MEM_TIMEOUT.
REQ-014 SHALL clear the wait counter in RUN and increment it each MEM_WAIT cycle, so the timeout fires after MEM_TIMEOUT+1 consecutive mw cycles.
REQ-015 SHALL keep HALT absorbing until reset; halted = (state == HALT); mem_timeout is sticky.
REQ-016 SHALL increment stall_cycles each cycle if_stall is asserted and the state is not HALT, saturating at 0xFFFF_FFFF with no wrap.
REQ-017 SHALL, when mem_ready arrives the same cycle as mem_req (zero wait), cause no stall.

Reset
REQ-018 SHALL, while rst_n is 0 at a clock edge, force next state to RUN, wait counter to 0, stall_cycles to 0 and mem_timeout to 0.
REQ-019 SHALL deassert all stall/flush/bubble outputs and hold fwd selects at 0 while rst_n is 0.
REQ-020 SHALL let reset in MEM_WAIT or HALT abandon the operation, so RUN is in effect on the first cycle after rst_n rises.

Verification
REQ-021 SHALL be covered by these directed scenarios:
- Load-use: EX = load to x5 and ID reads rs2 = x5 -> one cycle with if_stall = id_stall = ex_bubble = 1; next cycle (load in MEM, ID rs2 = x5) gives fwd_rs2_sel = 2 and no stall; stall_cycles = 1.
- Forward priority: EX and MEM both write x7 (EX non-load) and ID reads rs1 = x7 -> fwd_rs1_sel = 1; same case with x0 -> fwd_rs1_sel = 0.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then 1 -> if/id/ex/mem stalls and wb_bubble for 3 cycles, RUN on the 4th cycle, stall_cycles = 3; a simultaneous load_use or id_redirect produces no ex_bubble or flush during the wait.
- Redirect vs load-use: id_redirect together with load_use -> no if_id_flush that cycle; id_redirect alone next cycle -> if_id_flush = 1, with no stalls.
- Timeout: MEM_TIMEOUT = 4 and mem_ready held at 0 -> halted = mem_timeout = 1 after 5 wait cycles, everything frozen; rst_n low for one edge -> all outputs 0 and state RUN.
- Ebreak: wb_ebreak = 1 in RUN -> halted = 1 from the next cycle, with all stalls and wb_bubble held; stall_cycles stops counting.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core: load-use interlock,
// operand forwarding, memory-wait freeze, branch flush and halt handling.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_ren,
   input  logic        id_rs2_ren,
   input  logic [4:0]  ex_reg_waddr,
   input  logic        ex_reg_wen,
   input  logic        ex_is_load,
   input  logic [4:0]  mem_reg_waddr,
   input  logic        mem_reg_wen,
   input  logic        id_redirect,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        wb_ebreak,
   output logic        if_stall,
   output logic        id_stall,
   output logic        if_id_flush,
   output logic        ex_bubble,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        wb_bubble,
   output logic [1:0]  fwd_rs1_sel,
   output logic [1:0]  fwd_rs2_sel,
   output logic        halted,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT     = 2'd2;

   localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

   logic [1:0]  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_timeout_q, mem_timeout_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   logic        hz1, hz2, load_use, mw;
   logic        ex_fwd_ok, mem_fwd_ok;
   logic [8:0]  wait_next;
   logic        timeout_hit;

   assign ex_fwd_ok  = ex_reg_wen & (ex_reg_waddr != 5'd0) & ~ex_is_load;
   assign mem_fwd_ok = mem_reg_wen & (mem_reg_waddr != 5'd0);

   assign hz1 = ex_is_load & ex_reg_wen & (ex_reg_waddr != 5'd0) &
                id_rs1_ren & (ex_reg_waddr == id_rs1_addr);
   assign hz2 = ex_is_load & ex_reg_wen & (ex_reg_waddr != 5'd0) &
                id_rs2_ren & (ex_reg_waddr == id_rs2_addr);
   assign load_use = hz1 | hz2;
   assign mw       = mem_req & ~mem_ready;

   // The RUN cycle that first sees mw is the first wait cycle, so the
   // counter only has to count the MEM_WAIT cycles that follow it.
   assign wait_next   = {1'b0, wait_cnt_q} + 9'd1;
   assign timeout_hit = (wait_next >= TIMEOUT_LIMIT);

   always_comb begin
      if_stall    = 1'b0;
      id_stall    = 1'b0;
      if_id_flush = 1'b0;
      ex_bubble   = 1'b0;
      ex_stall    = 1'b0;
      mem_stall   = 1'b0;
      wb_bubble   = 1'b0;
      if (rst_n) begin
         if ((state_q == ST_HALT) || mw) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
            wb_bubble = 1'b1;
         end else if (load_use) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
         end else if (id_redirect) begin
            if_id_flush = 1'b1;
         end
      end
   end

   always_comb begin
      fwd_rs1_sel = 2'd0;
      fwd_rs2_sel = 2'd0;
      if (rst_n) begin
         if (ex_fwd_ok && (ex_reg_waddr == id_rs1_addr)) begin
            fwd_rs1_sel = 2'd1;
         end else if (mem_fwd_ok && (mem_reg_waddr == id_rs1_addr)) begin
            fwd_rs1_sel = 2'd2;
         end
         if (ex_fwd_ok && (ex_reg_waddr == id_rs2_addr)) begin
            fwd_rs2_sel = 2'd1;
         end else if (mem_fwd_ok && (mem_reg_waddr == id_rs2_addr)) begin
            fwd_rs2_sel = 2'd2;
         end
      end
   end

   // wb_ebreak is ignored under mw because WB then carries a bubble.
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q;

      if (if_stall && (state_q != ST_HALT) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end

      case (state_q)
         ST_RUN: begin
            wait_cnt_d = 8'd0;
            if (mw) begin
               state_d = ST_MEM_WAIT;
            end else if (wb_ebreak) begin
               state_d = ST_HALT;
            end
         end
         ST_MEM_WAIT: begin
            if (mw) begin
               if (timeout_hit) begin
                  state_d       = ST_HALT;
                  mem_timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_next[7:0];
               end
            end else begin
               wait_cnt_d = 8'd0;
               state_d    = wb_ebreak ? ST_HALT : ST_RUN;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (!rst_n) begin
         state_d        = ST_RUN;
         wait_cnt_d     = 8'd0;
         mem_timeout_d  = 1'b0;
         stall_cycles_d = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
   end

   assign halted       = (state_q == ST_HALT);
   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   typedef struct packed {
      logic       rst_n;
      logic [4:0] id_rs1_addr;
      logic [4:0] id_rs2_addr;
      logic       id_rs1_ren;
      logic       id_rs2_ren;
      logic [4:0] ex_reg_waddr;
      logic       ex_reg_wen;
      logic       ex_is_load;
      logic [4:0] mem_reg_waddr;
      logic       mem_reg_wen;
      logic       id_redirect;
      logic       mem_req;
      logic       mem_ready;
      logic       wb_ebreak;
   } stim_t;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs1_addr, id_rs2_addr;
   logic        id_rs1_ren, id_rs2_ren;
   logic [4:0]  ex_reg_waddr;
   logic        ex_reg_wen, ex_is_load;
   logic [4:0]  mem_reg_waddr;
   logic        mem_reg_wen, id_redirect, mem_req, mem_ready, wb_ebreak;
   logic        if_stall, id_stall, if_id_flush, ex_bubble, ex_stall, mem_stall, wb_bubble;
   logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
   logic        halted, mem_timeout;
   logic [31:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   // Model state: halt/timeout flags, length of the current run of wait cycles, stall count
   bit     m_halted  = 1'b0;
   bit     m_timeout = 1'b0;
   int     m_wait_run = 0;
   longint m_stalls  = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
      .ex_reg_waddr(ex_reg_waddr), .ex_reg_wen(ex_reg_wen), .ex_is_load(ex_is_load),
      .mem_reg_waddr(mem_reg_waddr), .mem_reg_wen(mem_reg_wen),
      .id_redirect(id_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .wb_ebreak(wb_ebreak),
      .if_stall(if_stall), .id_stall(id_stall), .if_id_flush(if_id_flush),
      .ex_bubble(ex_bubble), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .wb_bubble(wb_bubble), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
      .halted(halted), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic bit modelMw(stim_t s);
      return s.mem_req && !s.mem_ready;
   endfunction

   function automatic bit modelLoadUse(stim_t s);
      bit loadWrites;
      loadWrites = s.ex_is_load && s.ex_reg_wen && (s.ex_reg_waddr != 0);
      return loadWrites && ((s.id_rs1_ren && s.ex_reg_waddr == s.id_rs1_addr) ||
                            (s.id_rs2_ren && s.ex_reg_waddr == s.id_rs2_addr));
   endfunction

   // {if_stall, id_stall, if_id_flush, ex_bubble, ex_stall, mem_stall, wb_bubble}
   function automatic logic [6:0] modelCtrl(stim_t s);
      if (!s.rst_n) return 7'b0000000;
      if (m_halted || modelMw(s)) return 7'b1100111;
      if (modelLoadUse(s)) return 7'b1101000;
      if (s.id_redirect) return 7'b0010000;
      return 7'b0000000;
   endfunction

   function automatic logic [1:0] modelFwd(stim_t s, logic [4:0] src);
      if (!s.rst_n || src == 0) return 2'd0;
      if (s.ex_reg_wen && !s.ex_is_load && s.ex_reg_waddr == src) return 2'd1;
      if (s.mem_reg_wen && s.mem_reg_waddr == src) return 2'd2;
      return 2'd0;
   endfunction

   task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(stim_t s);
      @(negedge clk);
      rst_n         = s.rst_n;
      id_rs1_addr   = s.id_rs1_addr;
      id_rs2_addr   = s.id_rs2_addr;
      id_rs1_ren    = s.id_rs1_ren;
      id_rs2_ren    = s.id_rs2_ren;
      ex_reg_waddr  = s.ex_reg_waddr;
      ex_reg_wen    = s.ex_reg_wen;
      ex_is_load    = s.ex_is_load;
      mem_reg_waddr = s.mem_reg_waddr;
      mem_reg_wen   = s.mem_reg_wen;
      id_redirect   = s.id_redirect;
      mem_req       = s.mem_req;
      mem_ready     = s.mem_ready;
      wb_ebreak     = s.wb_ebreak;
      #1;
   endtask

   task automatic checkOutput(string tag, stim_t s);
      checkVal({tag, "_ctrl"}, {25'd0, if_stall, id_stall, if_id_flush, ex_bubble,
                                ex_stall, mem_stall, wb_bubble}, {25'd0, modelCtrl(s)});
      checkVal({tag, "_fwd1"}, {30'd0, fwd_rs1_sel}, {30'd0, modelFwd(s, s.id_rs1_addr)});
      checkVal({tag, "_fwd2"}, {30'd0, fwd_rs2_sel}, {30'd0, modelFwd(s, s.id_rs2_addr)});
      checkVal({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
      checkVal({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, m_timeout});
      checkVal({tag, "_stalls"}, stall_cycles, m_stalls[31:0]);
   endtask

   // Advance one clock edge and move the model along with the same inputs
   task automatic tick(stim_t s);
      logic [6:0] ctrl;
      ctrl = modelCtrl(s);
      @(posedge clk);
      if (!s.rst_n) begin
         m_halted   = 1'b0;
         m_timeout  = 1'b0;
         m_wait_run = 0;
         m_stalls   = 0;
      end else begin
         if (ctrl[6] && !m_halted && m_stalls < 64'hFFFF_FFFF) m_stalls++;
         if (!m_halted) begin
            if (modelMw(s)) begin
               m_wait_run++;
               if (m_wait_run == TMO + 1) begin
                  m_halted  = 1'b1;
                  m_timeout = 1'b1;
               end
            end else begin
               m_wait_run = 0;
               if (s.wb_ebreak) m_halted = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic runCycle(string tag, stim_t s);
      applyStimulus(s);
      checkOutput(tag, s);
      tick(s);
   endtask

   initial begin
      stim_t s;
      int haltAge;

      // Reset: DUT state is unknown before the first edge, so only clock it
      s = idle();
      s.rst_n = 1'b0;
      applyStimulus(s);
      tick(s);
      runCycle("reset", s);

      // Load-use on rs2 then forward from MEM
      s = idle();
      s.ex_is_load = 1; s.ex_reg_wen = 1; s.ex_reg_waddr = 5;
      s.id_rs2_addr = 5; s.id_rs2_ren = 1;
      applyStimulus(s);
      checkOutput("lu", s);
      checkVal("lu_bubble", {31'd0, ex_bubble}, 32'd1);
      tick(s);
      s = idle();
      s.mem_reg_wen = 1; s.mem_reg_waddr = 5;
      s.id_rs2_addr = 5; s.id_rs2_ren = 1;
      applyStimulus(s);
      checkOutput("lu_next", s);
      checkVal("lu_fwd2", {30'd0, fwd_rs2_sel}, 32'd2);
      checkVal("lu_nostall", {31'd0, if_stall}, 32'd0);
      checkVal("lu_count", stall_cycles, 32'd1);
      tick(s);

      // EX beats MEM; x0 never forwarded
      s = idle();
      s.ex_reg_wen = 1; s.ex_reg_waddr = 7;
      s.mem_reg_wen = 1; s.mem_reg_waddr = 7;
      s.id_rs1_addr = 7; s.id_rs1_ren = 1;
      applyStimulus(s);
      checkOutput("fwd_pri", s);
      checkVal("fwd_pri_sel", {30'd0, fwd_rs1_sel}, 32'd1);
      tick(s);
      s.ex_reg_waddr = 0; s.mem_reg_waddr = 0; s.id_rs1_addr = 0;
      applyStimulus(s);
      checkOutput("fwd_x0", s);
      checkVal("fwd_x0_sel", {30'd0, fwd_rs1_sel}, 32'd0);
      tick(s);

      // Three wait cycles with load-use and redirect pending
      for (int i = 0; i < 3; i++) begin
         s = idle();
         s.mem_req = 1; s.mem_ready = 0; s.id_redirect = 1;
         s.ex_is_load = 1; s.ex_reg_wen = 1; s.ex_reg_waddr = 9;
         s.id_rs1_addr = 9; s.id_rs1_ren = 1;
         applyStimulus(s);
         checkOutput("mw", s);
         checkVal("mw_noflush", {30'd0, ex_bubble, if_id_flush}, 32'd0);
         checkVal("mw_wb_bubble", {31'd0, wb_bubble}, 32'd1);
         tick(s);
      end
      s = idle();
      s.mem_req = 1; s.mem_ready = 1;
      applyStimulus(s);
      checkOutput("mw_done", s);
      checkVal("mw_done_stall", {31'd0, if_stall}, 32'd0);
      checkVal("mw_count", stall_cycles, 32'd4);
      tick(s);

      // Redirect loses to load-use, then wins alone
      s = idle();
      s.ex_is_load = 1; s.ex_reg_wen = 1; s.ex_reg_waddr = 3;
      s.id_rs1_addr = 3; s.id_rs1_ren = 1; s.id_redirect = 1;
      applyStimulus(s);
      checkOutput("rd_lu", s);
      checkVal("rd_lu_flush", {31'd0, if_id_flush}, 32'd0);
      tick(s);
      s = idle();
      s.id_redirect = 1;
      applyStimulus(s);
      checkOutput("rd", s);
      checkVal("rd_flush", {31'd0, if_id_flush}, 32'd1);
      checkVal("rd_nostall", {31'd0, if_stall}, 32'd0);
      tick(s);

      // Timeout after TMO+1 wait cycles, then frozen
      s = idle();
      s.mem_req = 1; s.mem_ready = 0;
      for (int i = 0; i < TMO + 1; i++) runCycle("tmo_wait", s);
      checkVal("tmo_halted", {31'd0, halted}, 32'd1);
      checkVal("tmo_flag", {31'd0, mem_timeout}, 32'd1);
      checkVal("tmo_count", stall_cycles, 32'd10);
      s.mem_ready = 1; s.id_redirect = 1;
      for (int i = 0; i < 3; i++) runCycle("tmo_frozen", s);
      checkVal("tmo_count_frozen", stall_cycles, 32'd10);
      s = idle();
      s.rst_n = 1'b0;
      runCycle("tmo_reset", s);
      s = idle();
      applyStimulus(s);
      checkOutput("tmo_after", s);
      checkVal("tmo_after_halted", {31'd0, halted}, 32'd0);
      checkVal("tmo_after_flag", {31'd0, mem_timeout}, 32'd0);
      checkVal("tmo_after_count", stall_cycles, 32'd0);
      tick(s);

      // Ebreak halts; counter stops
      s = idle();
      s.wb_ebreak = 1;
      runCycle("eb", s);
      checkVal("eb_halted", {31'd0, halted}, 32'd1);
      s = idle();
      for (int i = 0; i < 3; i++) runCycle("eb_hold", s);
      checkVal("eb_wb_bubble", {31'd0, wb_bubble}, 32'd1);
      checkVal("eb_count", stall_cycles, 32'd0);
      s.rst_n = 1'b0;
      runCycle("eb_reset", s);

      // Random traffic on a small register window to provoke matches
      haltAge = 0;
      for (int i = 0; i < 800; i++) begin
         s = idle();
         s.id_rs1_addr   = 5'($urandom_range(0, 3));
         s.id_rs2_addr   = 5'($urandom_range(0, 3));
         s.id_rs1_ren    = 1'($urandom_range(0, 1));
         s.id_rs2_ren    = 1'($urandom_range(0, 1));
         s.ex_reg_waddr  = 5'($urandom_range(0, 3));
         s.ex_reg_wen    = 1'($urandom_range(0, 1));
         s.ex_is_load    = 1'($urandom_range(0, 1));
         s.mem_reg_waddr = 5'($urandom_range(0, 3));
         s.mem_reg_wen   = 1'($urandom_range(0, 1));
         s.id_redirect   = ($urandom_range(0, 3) == 0);
         s.mem_req       = ($urandom_range(0, 2) == 0);
         s.mem_ready     = 1'($urandom_range(0, 1));
         s.wb_ebreak     = ($urandom_range(0, 49) == 0);
         haltAge = m_halted ? haltAge + 1 : 0;
         if (haltAge > 4 || $urandom_range(0, 63) == 0) s.rst_n = 1'b0;
         runCycle("rand", s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
